// File: rtl/serial_mag_comp_if.sv
// Request/response bundle for serial_mag_comp: operand request in, one-hot compare result out.
interface serial_mag_comp_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a_in;
  logic [DATA_WIDTH-1:0] b_in;
  logic [2:0]            casc_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [2:0]            result;
  logic                  busy;

  modport master (
    output in_valid, a_in, b_in, casc_in, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, casc_in, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/serial_mag_comp.sv
// Multi-cycle unsigned magnitude comparator: walks captured operands one slice per clock,
// MSB slice first, stopping at the first unequal slice and emitting a {gt,eq,lt} code.
module serial_mag_comp #(
  parameter int DATA_WIDTH  = 16,
  parameter int SLICE_WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  serial_mag_comp_if.slave bus
);
  localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_SLICES - 1);
  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_LT = 3'b001;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPARE = 2'b01,
    DONE    = 2'b10
  } state_t;

  state_t                  state_r, next_state_s;
  logic [IDX_W-1:0]        idx_r, next_idx_s;
  logic [DATA_WIDTH-1:0]   a_r, next_a_s;
  logic [DATA_WIDTH-1:0]   b_r, next_b_s;
  logic [2:0]              casc_r, next_casc_s;
  logic [2:0]              result_r, next_result_s;
  logic                    out_valid_r, next_out_valid_s;
  logic                    busy_r, next_busy_s;
  logic [SLICE_WIDTH-1:0]  a_slice_s, b_slice_s;

  function automatic logic [SLICE_WIDTH-1:0] get_slice(
    input logic [DATA_WIDTH-1:0] data,
    input logic [IDX_W-1:0]      idx
  );
    get_slice = data[int'(idx) * SLICE_WIDTH +: SLICE_WIDTH];
  endfunction

  // Select the slice pair under comparison this cycle.
  always_comb begin
    a_slice_s = get_slice(a_r, idx_r);
    b_slice_s = get_slice(b_r, idx_r);
  end

  // Next-state and next-register logic for the compare FSM.
  always_comb begin
    next_state_s     = state_r;
    next_idx_s       = idx_r;
    next_a_s         = a_r;
    next_b_s         = b_r;
    next_casc_s      = casc_r;
    next_result_s    = result_r;
    next_out_valid_s = out_valid_r;
    next_busy_s      = busy_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          next_a_s     = bus.a_in;
          next_b_s     = bus.b_in;
          next_casc_s  = bus.casc_in;
          next_idx_s   = IDX_TOP;
          next_busy_s  = 1'b1;
          next_state_s = COMPARE;
        end else begin
          next_state_s = IDLE;
        end
      end
      COMPARE: begin
        if (a_slice_s > b_slice_s) begin
          next_result_s    = RES_GT;
          next_out_valid_s = 1'b1;
          next_state_s     = DONE;
        end else if (a_slice_s < b_slice_s) begin
          next_result_s    = RES_LT;
          next_out_valid_s = 1'b1;
          next_state_s     = DONE;
        end else if (idx_r == {IDX_W{1'b0}}) begin
          // All slices equal: the cascade code passes through unvalidated.
          next_result_s    = casc_r;
          next_out_valid_s = 1'b1;
          next_state_s     = DONE;
        end else begin
          next_idx_s   = idx_r - IDX_W'(1'b1);
          next_state_s = COMPARE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          next_out_valid_s = 1'b0;
          next_busy_s      = 1'b0;
          next_state_s     = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_out_valid_s = 1'b0;
        next_busy_s      = 1'b0;
        next_state_s     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= IDX_TOP;
      a_r         <= {DATA_WIDTH{1'b0}};
      b_r         <= {DATA_WIDTH{1'b0}};
      casc_r      <= 3'b000;
      result_r    <= 3'b000;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      idx_r       <= next_idx_s;
      a_r         <= next_a_s;
      b_r         <= next_b_s;
      casc_r      <= next_casc_s;
      result_r    <= next_result_s;
      out_valid_r <= next_out_valid_s;
      busy_r      <= next_busy_s;
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench for serial_mag_comp: directed scenarios plus randomized back-to-back ops
// checked against a plain-arithmetic reference compare and latency model.
module tb_serial_mag_comp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  serial_mag_comp_if #(.DATA_WIDTH(16)) bus ();

  serial_mag_comp #(.DATA_WIDTH(16), .SLICE_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] c);
    if (a > b) return 3'b100;
    else if (a < b) return 3'b001;
    else return c;
  endfunction

  // Edges from accept to out_valid: 1 + leading equal nibbles, from the top differing bit.
  function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    int msb;
    x = a ^ b;
    msb = -1;
    for (int i = 0; i < 16; i++) if (x[i]) msb = i;
    if (msb < 0) return 4;
    return 4 - msb / 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
    bus.a_in = a; bus.b_in = b; bus.casc_in = c; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a_in = 16'($urandom); bus.b_in = 16'($urandom); bus.casc_in = 3'($urandom);
  endtask

  task automatic wait_done(output int lat, output bit busy_ok, output bit timed_out);
    lat = 0; busy_ok = 1'b1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
    timed_out = (bus.out_valid !== 1'b1);
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (bus.result !== 3'b000) begin errors++; $display("FAIL reset_result got=%b exp=000", bus.result); end
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_early_exit();
    int lat; bit bok, to;
    start_op(16'h1234, 16'h0234, 3'b010);
    wait_done(lat, bok, to);
    vectors++; if (to) begin errors++; $display("FAIL early_timeout got=no out_valid exp=out_valid"); end
    vectors++; if (bus.result !== ref_result(16'h1234, 16'h0234, 3'b010)) begin errors++; $display("FAIL early_result got=%b exp=100", bus.result); end
    vectors++; if (lat != ref_lat(16'h1234, 16'h0234)) begin errors++; $display("FAIL early_latency got=%0d exp=1", lat); end
    finish_op();
    vectors++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL early_return got=in_ready %b out_valid %b exp=1 0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_full_walk();
    int lat; bit bok, to;
    start_op(16'hABC5, 16'hABC7, 3'b010);
    wait_done(lat, bok, to);
    vectors++; if (to) begin errors++; $display("FAIL walk_timeout got=no out_valid exp=out_valid"); end
    vectors++; if (bus.result !== 3'b001) begin errors++; $display("FAIL walk_result got=%b exp=001", bus.result); end
    vectors++; if (lat != 4) begin errors++; $display("FAIL walk_latency got=%0d exp=4", lat); end
    vectors++; if (!bok) begin errors++; $display("FAIL walk_busy got=low exp=high throughout"); end
    finish_op();
  endtask

  task automatic test_casc_passthrough();
    logic [2:0] codes [3];
    int lat; bit bok, to;
    codes[0] = 3'b100; codes[1] = 3'b010; codes[2] = 3'b111;
    for (int i = 0; i < 3; i++) begin
      start_op(16'h5A5A, 16'h5A5A, codes[i]);
      wait_done(lat, bok, to);
      vectors++; if (to || bus.result !== codes[i]) begin errors++; $display("FAIL casc_result got=%b exp=%b", bus.result, codes[i]); end
      vectors++; if (lat != 4) begin errors++; $display("FAIL casc_latency got=%0d exp=4", lat); end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit bok, to;
    start_op(16'hF000, 16'h1000, 3'b010);
    wait_done(lat, bok, to);
    vectors++; if (to || lat != 1) begin errors++; $display("FAIL bp_latency got=%0d exp=1", lat); end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0]; bus.a_in = 16'h0000; bus.b_in = 16'hFFFF; bus.casc_in = 3'b111;
      tick();
      vectors++; if (bus.out_valid !== 1'b1 || bus.result !== 3'b100) begin errors++; $display("FAIL bp_hold got=%b/%b exp=1/100", bus.out_valid, bus.result); end
      vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    finish_op();
    vectors++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 3'b100) begin errors++; $display("FAIL bp_release got=%b/%b/%b exp=1/0/100", bus.in_ready, bus.out_valid, bus.result); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_buffer got=busy %b out_valid %b exp=0 0", bus.busy, bus.out_valid); end
    end
  endtask

  task automatic test_mid_reset();
    int lat; bit bok, to;
    start_op(16'hFFF0, 16'hFFF1, 3'b010);
    tick(); tick();
    vectors++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL mr_inflight got=busy %b out_valid %b exp=1 0", bus.busy, bus.out_valid); end
    #1 rst = 1'b1;
    #1;
    vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL mr_abort got=%b/%b/%b exp=0/0/1", bus.out_valid, bus.busy, bus.in_ready); end
    vectors++; if (bus.result !== 3'b000) begin errors++; $display("FAIL mr_result got=%b exp=000", bus.result); end
    @(negedge clk); rst = 1'b0;
    start_op(16'h0001, 16'h0000, 3'b010);
    wait_done(lat, bok, to);
    vectors++; if (to || bus.result !== 3'b100) begin errors++; $display("FAIL mr_next_result got=%b exp=100", bus.result); end
    vectors++; if (lat != 4) begin errors++; $display("FAIL mr_next_latency got=%0d exp=4", lat); end
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    logic [2:0]  c;
    int lat, k, prev_k, acc, prev_acc;
    bus.out_ready = 1'b1;
    prev_k = 0; prev_acc = 0;
    for (int op = 0; op < 1000; op++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 4))
        0: b = a;
        1: b = a ^ 16'($urandom_range(0, 15));
        2: b = a ^ 16'($urandom_range(0, 255));
        3: b = a ^ 16'($urandom_range(0, 4095));
        default: b = 16'($urandom);
      endcase
      c = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b010;
      k = ref_lat(a, b);
      bus.a_in = a; bus.b_in = b; bus.casc_in = c; bus.in_valid = 1'b1;
      vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready op=%0d got=%b exp=1", op, bus.in_ready); end
      tick();
      acc = cyc;
      bus.a_in = 16'($urandom); bus.b_in = 16'($urandom); bus.casc_in = 3'($urandom);
      if (op > 0) begin
        vectors++; if (acc - prev_acc != prev_k + 2) begin errors++; $display("FAIL b2b_spacing op=%0d got=%0d exp=%0d", op, acc - prev_acc, prev_k + 2); end
      end
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
      vectors++;
      if (bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_timeout op=%0d got=no out_valid exp=out_valid", op);
        break;
      end
      if (bus.result !== ref_result(a, b, c) || lat != k) begin
        errors++;
        $display("FAIL b2b_result op=%0d a=%h b=%h got=%b lat %0d exp=%b lat %0d", op, a, b, bus.result, lat, ref_result(a, b, c), k);
      end
      tick();
      prev_k = k; prev_acc = acc;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a_in = 16'h0000; bus.b_in = 16'h0000; bus.casc_in = 3'b010;
    test_reset();
    test_early_exit();
    test_full_walk();
    test_casc_passthrough();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
- Multi-cycle magnitude comparator for operands wider than the 4-bit cascadable comparator slice.
- Walks A and B one slice per clock, MSB slice first, threading the 3-bit cascade code between slices.
- Terminates early on the first unequal slice.
- Sits directly upstream of result consumers. Emits the same {gt,eq,lt} one-hot code the slice comparator uses.

Parameters:
- DATA_WIDTH, 16: operand width. Must be an integer multiple of SLICE_WIDTH.
- SLICE_WIDTH, 4: bits compared per cycle.
- NUM_SLICES, DATA_WIDTH/SLICE_WIDTH: derived, local.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept; equals (state==IDLE)
- a_in  input  DATA_WIDTH  operand A, unsigned
- b_in  input  DATA_WIDTH  operand B, unsigned
- casc_in  input  3  cascade code returned when A==B over all slices (3'b010 for standalone use)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  3  3'b100 A>B, 3'b001 A<B, otherwise captured casc_in
- busy  output  1  high in COMPARE or DONE

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: state=IDLE, result=3'b000, out_valid=0, busy=0, slice index=NUM_SLICES-1, captured regs=0. in_ready=1 from state.
- States: IDLE, COMPARE, DONE.
- IDLE:
  - On edge with in_valid&in_ready: capture a_in, b_in, casc_in; idx=NUM_SLICES-1; go to COMPARE.
  - Otherwise hold.
- COMPARE (one slice per cycle): compare slice idx of captured A and B, as unsigned SLICE_WIDTH values.
  - A slice > B slice: result<=3'b100, go to DONE.
  - A slice < B slice: result<=3'b001, go to DONE.
  - Equal and idx==0: result<=captured casc_in verbatim (illegal codes such as 000 or 111 pass through unchanged), go to DONE.
  - Equal and idx>0: idx<=idx-1, stay in COMPARE.
- Latency: out_valid rises k edges after the accept edge, where k = 1 + number of leading equal slices (1..NUM_SLICES).
- DONE:
  - out_valid=1. result held stable until the out_ready handshake.
  - On out_valid&out_ready: go to IDLE, out_valid<=0. result keeps its last value.
- in_ready=0 outside IDLE. in_valid outside IDLE is ignored, with no buffering.
- Minimum initiation interval is k+2 cycles (accept, k compares, DONE handshake, back to IDLE).
- Inputs a_in, b_in, casc_in may change freely after the accept edge; only the captured copies are used.
- Reset mid-operation: abort immediately and discard the operation. out_valid drops asynchronously, and no partial result is ever presented.
- Slice compare is purely unsigned; no signed mode.

Test Plan:
- a=0x1234, b=0x0234, casc=010 -> result=100, out_valid exactly 1 edge after accept.
- a=0xABC5, b=0xABC7, casc=010 -> result=001 after 4 compare edges; busy high throughout.
- a=b=0x5A5A with casc=100, then casc=010, then casc=111 -> result=100, 010, 111 respectively, each after 4 compares.
- a=0xF000, b=0x1000, out_ready held low 5 cycles -> out_valid and result=100 stable, in_ready=0; in_valid pulses with new operands are ignored; handshake then returns to IDLE.
- rst pulsed mid-COMPARE of a=0xFFF0, b=0xFFF1 -> out_valid=0, busy=0, in_ready=1 immediately. A following a=0x0001, b=0x0000 gives 100 after 4 compares.
- in_valid and out_ready tied high, random 16-bit pairs (1000 ops) -> every result matches a reference compare; spacing per op equals k+2 cycles.
